ifu: RTL and testbench
======================

# ifu

Instruction fetch unit of the pipelined MIPS core. It holds the program counter and drives it combinationally to the instruction memory. It captures the returned instruction into the IF/ID pipeline register and computes the next PC. Next-PC sources are sequential, branch, j/jal and jr, and the redirect is resolved from the instruction sitting in ID. It sits directly upstream of the instruction memory and feeds the decode stage.

## Interface
- RESET_PC, 32'h0000_3000, PC value after reset (first fetched word).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; all state to reset values.
- stall  in  1  hazard stall from ID; holds PC and IF/ID.
- flush  in  1  clears IF/ID to a bubble on the next edge.
- npc_sel  in  2  next-PC source for the ID instruction: 00 seq, 01 branch, 10 jump-index, 11 register.
- branch_taken  in  1  branch condition result; meaningful only when npc_sel=01.
- imm16  in  16  branch offset field of the ID instruction.
- instr_index  in  26  j/jal target field of the ID instruction.
- rs_val  in  32  forwarded rs value for jr.
- pc  out  32  current fetch address, to instruction memory.
- instr_in  in  32  instruction word returned by memory for `pc` (combinational, same cycle).
- if_id_instr  out  32  registered instruction for ID.
- if_id_pc  out  32  registered PC of if_id_instr.
- if_id_pc8  out  32  if_id_pc + 8, the link address for jal.
- if_id_valid  out  1  IF/ID holds a real instruction.
- addr_err  out  1  sticky flag: a redirect target was not word-aligned.

## Operation
- Redirect target computation is combinational and based on if_id_pc:
  - branch: if_id_pc + 4 + (sign_ext(imm16) << 2), mod 2^32.
  - jump-index: {if_id_pc_plus4[31:28], instr_index, 2'b00}.
  - register: rs_val.
- A redirect is in effect when if_id_valid=1 and one of the following holds:
  - npc_sel=01 with branch_taken=1;
  - npc_sel=10;
  - npc_sel=11.
  - Otherwise the next PC is pc + 4 (wraps mod 2^32).
- Priority at each edge: reset > stall > redirect > sequential.
- Stall=1: pc, if_id_* and if_id_valid all hold. A concurrent redirect is dropped, and ID re-presents it after the stall. A concurrent flush is also ignored.
- Flush=1 with stall=0:
  - IF/ID loads instr 0 (nop), pc 0, pc8 0, valid 0.
  - pc still updates normally (redirect or seq).
- Normal capture: IF/ID loads instr_in, pc, pc+8, valid 1.
- Delay slot is architectural. The word at if_id_pc+4 is fetched in the redirect cycle and enters IF/ID normally.
- Misaligned target (target[1:0]!=0, only possible for register):
  - pc loads target with bits [1:0] forced to 00;
  - addr_err sets to 1 and stays 1 until reset.

## Timing
- Reset values: pc=RESET_PC, if_id_instr=0, if_id_pc=0, if_id_pc8=0, if_id_valid=0, addr_err=0. Reset takes effect immediately, independent of clk.
- Fetch latency: instr_in for pc is valid in the same cycle and appears on if_id_instr after the next rising edge (1 cycle).
- Redirect: the redirect condition is seen in cycle N, so pc equals the target in cycle N+1. The delay-slot word enters IF/ID at the end of cycle N, and the target word enters at the end of cycle N+1.
- First cycle after reset release: if_id_valid=0. Any npc_sel is therefore ignored and the next pc is RESET_PC+4.
- Stall of k cycles: pc and IF/ID stay frozen for exactly k edges, with no lost or duplicated fetch.
- Reset asserted mid-stall or mid-redirect: reset values take effect immediately. No pending redirect survives.

## Structure
- Shared package holds:
  - npc_sel encodings NPC_SEQ/NPC_BR/NPC_J/NPC_JR;
  - RESET_PC default;
  - NOP word 32'h0000_0000.
- One combinational sub-module, `npc`. It takes if_id_pc, npc_sel, branch_taken, imm16, instr_index, rs_val and pc, and returns next_pc and misalign.
- `ifu` holds the PC register, the IF/ID register and the addr_err flag.

## Test plan
- Reset then 4 free-running cycles with no redirect -> pc 0x3000, 0x3004, 0x3008, 0x300C. if_id_valid=0 in the first cycle, then 1 with if_id_pc lagging pc by one cycle. if_id_pc8 = if_id_pc + 8.
- Branch from ID instruction at 0x3004 with npc_sel=01, branch_taken=1, imm16=0xFFFF -> next pc 0x3004 (0x3008-4). The delay-slot word at 0x3008 is still captured.
- jal with if_id_pc=0x3010 and instr_index=0x0000C40 -> next pc 0x3100, if_id_pc8=0x3018.
- Stall held 3 cycles while npc_sel=11 and rs_val=0x3200 -> pc and IF/ID unchanged for 3 edges. After release with the request re-presented, pc=0x3200.
- jr with rs_val=0x3202 -> pc=0x3200 and addr_err=1. addr_err stays 1 through later fetches until reset is asserted asynchronously between edges, when all outputs return to reset values at once.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: next-PC source encodings,
// reset PC and the bubble instruction word.
package ifu_pkg;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'b00,
        NPC_BR  = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_sel_e;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/ifu_npc.sv
// Combinational next-PC selection: sequential, branch, j/jal or jr target,
// with word-alignment of the selected redirect target.
module npc
    import ifu_pkg::*;
(
    input  logic [31:0] if_id_pc_i,
    input  npc_sel_e    npc_sel_i,
    input  logic        branch_taken_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] instr_index_i,
    input  logic [31:0] rs_val_i,
    input  logic [31:0] pc_i,
    output logic [31:0] next_pc_o,
    output logic        misalign_o
);

    logic [31:0] pc_plus4;
    logic [31:0] if_id_plus4;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] target;
    logic        redirect;

    assign pc_plus4    = pc_i + 32'd4;
    assign if_id_plus4 = if_id_pc_i + 32'd4;
    assign br_target   = if_id_plus4 + (sign_ext16(imm16_i) << 2);
    assign j_target    = {if_id_plus4[31:28], instr_index_i, 2'b00};

    always_comb begin
        redirect = 1'b0;
        target   = rs_val_i;
        unique case (npc_sel_i)
            NPC_BR: begin
                redirect = branch_taken_i;
                target   = br_target;
            end
            NPC_J: begin
                redirect = 1'b1;
                target   = j_target;
            end
            NPC_JR: begin
                redirect = 1'b1;
                target   = rs_val_i;
            end
            default: begin
                redirect = 1'b0;
                target   = rs_val_i;
            end
        endcase
    end

    // Only a register target can be misaligned; fetch still proceeds from the word address.
    assign next_pc_o  = redirect ? {target[31:2], 2'b00} : pc_plus4;
    assign misalign_o = redirect && (target[1:0] != 2'b00);

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC register, IF/ID pipeline register and sticky
// misaligned-target flag. Redirects are resolved from the instruction in ID.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] ResetPc = RESET_PC
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [1:0]  npc_sel_i,
    input  logic        branch_taken_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] instr_index_i,
    input  logic [31:0] rs_val_i,
    output logic [31:0] pc_o,
    input  logic [31:0] instr_in_i,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc8_o,
    output logic        if_id_valid_o,
    output logic        addr_err_o
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_pc8_q, if_id_pc8_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic        addr_err_q, addr_err_d;

    npc_sel_e    sel_eff;
    logic [31:0] next_pc;
    logic        misalign;

    // A bubble in ID cannot redirect, whatever npc_sel says.
    assign sel_eff = if_id_valid_q ? npc_sel_e'(npc_sel_i) : NPC_SEQ;

    npc u_npc (
        .if_id_pc_i    (if_id_pc_q),
        .npc_sel_i     (sel_eff),
        .branch_taken_i(branch_taken_i),
        .imm16_i       (imm16_i),
        .instr_index_i (instr_index_i),
        .rs_val_i      (rs_val_i),
        .pc_i          (pc_q),
        .next_pc_o     (next_pc),
        .misalign_o    (misalign)
    );

    always_comb begin
        pc_d          = pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_pc8_d   = if_id_pc8_q;
        if_id_valid_d = if_id_valid_q;
        addr_err_d    = addr_err_q;
        if (!stall_i) begin
            pc_d = next_pc;
            if (misalign) begin
                addr_err_d = 1'b1;
            end
            if (flush_i) begin
                if_id_instr_d = NOP_WORD;
                if_id_pc_d    = 32'h0;
                if_id_pc8_d   = 32'h0;
                if_id_valid_d = 1'b0;
            end else begin
                if_id_instr_d = instr_in_i;
                if_id_pc_d    = pc_q;
                if_id_pc8_d   = pc_q + 32'd8;
                if_id_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pc_q          <= ResetPc;
            if_id_instr_q <= NOP_WORD;
            if_id_pc_q    <= 32'h0;
            if_id_pc8_q   <= 32'h0;
            if_id_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_pc8_q   <= if_id_pc8_d;
            if_id_valid_q <= if_id_valid_d;
            addr_err_q    <= addr_err_d;
        end
    end

    assign pc_o          = pc_q;
    assign if_id_instr_o = if_id_instr_q;
    assign if_id_pc_o    = if_id_pc_q;
    assign if_id_pc8_o   = if_id_pc8_q;
    assign if_id_valid_o = if_id_valid_q;
    assign addr_err_o    = addr_err_q;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed fetch/redirect/stall scenarios plus a
// randomized run against an architectural fetch model.
module tb_ifu;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [1:0]  npc_sel;
    logic        branch_taken;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] rs_val;
    logic [31:0] pc;
    logic [31:0] instr_in;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc8;
    logic        if_id_valid;
    logic        addr_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural model state
    logic [31:0] m_pc, m_instr, m_ifid_pc;
    logic        m_valid, m_err;

    ifu dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .stall_i       (stall),
        .flush_i       (flush),
        .npc_sel_i     (npc_sel),
        .branch_taken_i(branch_taken),
        .imm16_i       (imm16),
        .instr_index_i (instr_index),
        .rs_val_i      (rs_val),
        .pc_o          (pc),
        .instr_in_i    (instr_in),
        .if_id_instr_o (if_id_instr),
        .if_id_pc_o    (if_id_pc),
        .if_id_pc8_o   (if_id_pc8),
        .if_id_valid_o (if_id_valid),
        .addr_err_o    (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    always_comb instr_in = mem_word(pc);

    task automatic model_reset();
        m_pc      = 32'h0000_3000;
        m_instr   = 32'h0;
        m_ifid_pc = 32'h0;
        m_valid   = 1'b0;
        m_err     = 1'b0;
    endtask

    task automatic model_edge();
        logic [31:0] tgt;
        logic        redir;
        if (stall) return;
        redir = m_valid && ((npc_sel == 2'b01 && branch_taken) || npc_sel == 2'b10 ||
                            npc_sel == 2'b11);
        case (npc_sel)
            2'b01:   tgt = m_ifid_pc + 32'd4 + 32'($signed(imm16)) * 32'd4;
            2'b10:   tgt = ((m_ifid_pc + 32'd4) & 32'hF000_0000) | ({6'b0, instr_index} * 32'd4);
            2'b11:   tgt = rs_val;
            default: tgt = 32'h0;
        endcase
        if (flush) begin
            m_instr   = 32'h0;
            m_ifid_pc = 32'h0;
            m_valid   = 1'b0;
        end else begin
            m_instr   = mem_word(m_pc);
            m_ifid_pc = m_pc;
            m_valid   = 1'b1;
        end
        if (redir) begin
            if (tgt % 4 != 0) m_err = 1'b1;
            m_pc = tgt - (tgt % 4);
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        stall        = 1'b0;
        flush        = 1'b0;
        npc_sel      = 2'b00;
        branch_taken = 1'b0;
        imm16        = 16'h0;
        instr_index  = 26'h0;
        rs_val       = 32'h0;
    endtask

    // Asynchronous reset pulse placed between edges.
    task automatic pulse_reset();
        reset = 1'b1;
        model_reset();
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        model_reset();
        #2;
        n_checks++;
        if (pc !== 32'h0000_3000 || if_id_instr !== 32'h0 || if_id_pc !== 32'h0 ||
            if_id_pc8 !== 32'h0 || if_id_valid !== 1'b0 || addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: got pc=%h instr=%h ipc=%h pc8=%h v=%b err=%b", pc,
                     if_id_instr, if_id_pc, if_id_pc8, if_id_valid, addr_err);
        end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        for (int k = 1; k <= 3; k++) begin
            step();
            n_checks++;
            if (pc !== 32'h3000 + 32'(4 * k) || if_id_pc !== pc - 32'd4 ||
                if_id_pc8 !== if_id_pc + 32'd8 || if_id_valid !== 1'b1 ||
                if_id_instr !== mem_word(if_id_pc)) begin
                n_fail++;
                $display("FAIL seq_fetch_%0d: got pc=%h ipc=%h pc8=%h v=%b, expected pc=%h", k,
                         pc, if_id_pc, if_id_pc8, if_id_valid, 32'h3000 + 32'(4 * k));
            end
        end
    endtask

    task automatic test_branch();
        pulse_reset();
        npc_sel      = 2'b01;
        branch_taken = 1'b1;
        imm16        = 16'hFFFF;
        step();
        n_checks++;
        // ID held a bubble: branch request ignored
        if (pc !== 32'h3004 || if_id_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL branch_ignored_in_bubble: got pc=%h expected 00003004", pc);
        end
        npc_sel = 2'b00;
        step();
        npc_sel = 2'b01;
        step();
        n_checks++;
        if (pc !== 32'h3004 || if_id_pc !== 32'h3008 || if_id_instr !== mem_word(32'h3008)) begin
            n_fail++;
            $display("FAIL branch_back: got pc=%h ipc=%h, expected pc=00003004 ipc=00003008", pc,
                     if_id_pc);
        end
        npc_sel = 2'b00;
        step();
        n_checks++;
        if (pc !== 32'h3008 || if_id_pc !== 32'h3004 || pc !== m_pc) begin
            n_fail++;
            $display("FAIL branch_target_fetch: got pc=%h ipc=%h expected 00003008/00003004", pc,
                     if_id_pc);
        end
    endtask

    task automatic test_jal_stall_jr();
        pulse_reset();
        idle_inputs();
        for (int k = 0; k < 5; k++) step();
        n_checks++;
        if (if_id_pc !== 32'h3010 || if_id_pc8 !== 32'h3018) begin
            n_fail++;
            $display("FAIL jal_link: got ipc=%h pc8=%h expected 00003010/00003018", if_id_pc,
                     if_id_pc8);
        end
        npc_sel     = 2'b10;
        instr_index = 26'h0000C40;
        step();
        n_checks++;
        if (pc !== 32'h3100 || if_id_pc !== 32'h3014) begin
            n_fail++;
            $display("FAIL jal_target: got pc=%h ipc=%h expected 00003100/00003014", pc, if_id_pc);
        end
        stall   = 1'b1;
        flush   = 1'b1;
        npc_sel = 2'b11;
        rs_val  = 32'h3200;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (pc !== 32'h3100 || if_id_pc !== 32'h3014 || if_id_valid !== 1'b1 ||
                if_id_instr !== mem_word(32'h3014)) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got pc=%h ipc=%h v=%b expected 00003100/00003014",
                         k, pc, if_id_pc, if_id_valid);
            end
        end
        stall = 1'b0;
        flush = 1'b0;
        step();
        n_checks++;
        if (pc !== 32'h3200 || if_id_pc !== 32'h3100 || addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release_jr: got pc=%h ipc=%h err=%b expected 00003200/00003100/0",
                     pc, if_id_pc, addr_err);
        end
        rs_val = 32'h3202;
        step();
        n_checks++;
        if (pc !== 32'h3200 || addr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL jr_misalign: got pc=%h err=%b expected 00003200/1", pc, addr_err);
        end
        idle_inputs();
        step();
        step();
        n_checks++;
        if (addr_err !== 1'b1 || pc !== 32'h3208) begin
            n_fail++;
            $display("FAIL err_sticky: got err=%b pc=%h expected 1/00003208", addr_err, pc);
        end
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (pc !== 32'h3000 || if_id_instr !== 32'h0 || if_id_pc !== 32'h0 ||
            if_id_pc8 !== 32'h0 || if_id_valid !== 1'b0 || addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got pc=%h ipc=%h v=%b err=%b", pc, if_id_pc, if_id_valid,
                     addr_err);
        end
        reset = 1'b0;
    endtask

    task automatic test_flush();
        pulse_reset();
        idle_inputs();
        step();
        flush = 1'b1;
        step();
        n_checks++;
        if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc8 !== 32'h0 ||
            pc !== 32'h3008) begin
            n_fail++;
            $display("FAIL flush_bubble: got v=%b instr=%h pc8=%h pc=%h expected 0/0/0/00003008",
                     if_id_valid, if_id_instr, if_id_pc8, pc);
        end
        flush   = 1'b0;
        npc_sel = 2'b10;
        step();
        n_checks++;
        if (pc !== 32'h300C || if_id_pc !== 32'h3008) begin
            n_fail++;
            $display("FAIL no_redirect_from_bubble: got pc=%h expected 0000300C", pc);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        pulse_reset();
        for (int i = 0; i < 400; i++) begin
            stall        = ($urandom_range(0, 4) == 0);
            flush        = ($urandom_range(0, 6) == 0);
            npc_sel      = 2'($urandom_range(0, 3));
            branch_taken = 1'($urandom);
            imm16        = 16'($urandom);
            instr_index  = 26'($urandom);
            rs_val       = $urandom & (($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            step();
            n_checks++;
            if (pc !== m_pc || if_id_instr !== m_instr || if_id_pc !== m_ifid_pc ||
                if_id_pc8 !== (m_valid ? m_ifid_pc + 32'd8 : 32'h0) || if_id_valid !== m_valid ||
                addr_err !== m_err) begin
                n_fail++;
                $display("FAIL random_%0d: got pc=%h ipc=%h v=%b err=%b, expected pc=%h ipc=%h v=%b err=%b",
                         i, pc, if_id_pc, if_id_valid, addr_err, m_pc, m_ifid_pc, m_valid, m_err);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jal_stall_jr();
        test_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
